// File: rtl/crtc_pkg.sv
// Shared definitions for the CRTC mode loader: register indices, the timing
// set layout, loader FSM states and the built-in mode table.
package crtc_pkg;

    // CRTC register indices on the 4-bit register bus
    localparam logic [3:0] H_START     = 4'd0;
    localparam logic [3:0] H_END       = 4'd1;
    localparam logic [3:0] HACT_END    = 4'd2;
    localparam logic [3:0] HSYNC_START = 4'd3;
    localparam logic [3:0] HSYNC_END   = 4'd4;
    localparam logic [3:0] V_START     = 4'd5;
    localparam logic [3:0] V_END       = 4'd6;
    localparam logic [3:0] VACT_END    = 4'd7;
    localparam logic [3:0] VSYNC_START = 4'd8;
    localparam logic [3:0] VSYNC_END   = 4'd9;
    localparam logic [3:0] HCNT        = 4'd10;
    localparam logic [3:0] VCNT        = 4'd11;

    localparam int NUM_TABLE_MODES = 4;

    // One complete timing set; field order matches the register write order
    typedef struct packed {
        logic [11:0] h_start;
        logic [11:0] h_end;
        logic [11:0] hact_end;
        logic [11:0] hsync_start;
        logic [11:0] hsync_end;
        logic [11:0] v_start;
        logic [11:0] v_end;
        logic [11:0] vact_end;
        logic [11:0] vsync_start;
        logic [11:0] vsync_end;
    } crtc_timing_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_VBL = 2'd1,
        ST_WRITE    = 2'd2
    } loader_state_t;

    // Mode 0: 320x240 NTSC-like, 1: 256x224, 2: 640x480, 3: 320x256
    localparam crtc_timing_t MODE_TABLE [NUM_TABLE_MODES] = '{
        '{12'd0, 12'd399, 12'd319, 12'd336, 12'd368, 12'd0, 12'd261, 12'd239, 12'd244, 12'd247},
        '{12'd0, 12'd340, 12'd255, 12'd280, 12'd305, 12'd0, 12'd261, 12'd223, 12'd234, 12'd237},
        '{12'd0, 12'd799, 12'd639, 12'd655, 12'd751, 12'd0, 12'd524, 12'd479, 12'd489, 12'd491},
        '{12'd0, 12'd399, 12'd319, 12'd336, 12'd368, 12'd0, 12'd311, 12'd255, 12'd270, 12'd273}
    };

    // Select one field of a timing set by register index; counters read as 0
    function automatic logic [11:0] timing_field(input crtc_timing_t t, input logic [3:0] idx);
        logic [11:0] v;
        case (idx)
            H_START:     v = t.h_start;
            H_END:       v = t.h_end;
            HACT_END:    v = t.hact_end;
            HSYNC_START: v = t.hsync_start;
            HSYNC_END:   v = t.hsync_end;
            V_START:     v = t.v_start;
            V_END:       v = t.v_end;
            VACT_END:    v = t.vact_end;
            VSYNC_START: v = t.vsync_start;
            VSYNC_END:   v = t.vsync_end;
            default:     v = 12'h000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/crtc_mode_rom.sv
// Combinational mode table lookup: (mode, register index) -> 12-bit value.
// Indices beyond the timing set (HCNT/VCNT) return 0.
module crtc_mode_rom
    import crtc_pkg::*;
#(
    parameter int MSEL_W = 2
) (
    input  logic [MSEL_W-1:0] mode,
    input  logic [3:0]        idx,
    output logic [11:0]       value
);

    logic [1:0] sel;

    // Table lookup; mode indices wrap onto the four built-in entries
    always_comb begin
        sel   = 2'(int'(mode) % NUM_TABLE_MODES);
        value = timing_field(MODE_TABLE[sel], idx);
    end

endmodule

// File: rtl/crtc_mode_loader.sv
// CRTC mode loader: on request, writes a full timing set from the built-in
// table over the shared CRTC register bus, stalling the host port meanwhile.
// Optional macro CRTC_LOADER_CNTRST_EN extends each load with zero writes to
// HCNT and VCNT so the raster restarts at 0,0 on the new timing.
//
// Host port handshake: host_ready is the only flow control. A host write
// (host_wr != 0) takes effect only in a cycle where host_ready is high; a
// write presented while host_ready is low is dropped, not queued, and the
// host must present it again once host_ready returns high.
module crtc_mode_loader
    import crtc_pkg::*;
#(
    parameter  int NUM_MODES      = 4,
    parameter  int SYNC_TO_VBLANK = 1,
    localparam int MSEL_W         = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode_req,
    input  logic [MSEL_W-1:0]   mode_sel,
    output logic                mode_busy,
    output logic                mode_done,
    output logic                mode_err,
    output logic [MSEL_W-1:0]   cur_mode,
    input  logic [1:0]          host_wr,
    input  logic [3:0]          host_address,
    input  logic [15:0]         host_din,
    output logic [15:0]         host_dout,
    output logic                host_ready,
    output logic [1:0]          crtc_wr,
    output logic [3:0]          crtc_address,
    output logic [15:0]         crtc_din,
    input  logic [15:0]         crtc_dout,
    input  logic                vblank,
    output loader_state_t       dbg_state
);

`ifdef CRTC_LOADER_CNTRST_EN
    localparam logic [3:0] LAST_IDX = VCNT;
`else
    localparam logic [3:0] LAST_IDX = VSYNC_END;
`endif

    loader_state_t     state, state_n;
    logic [3:0]        idx, idx_n;
    logic [MSEL_W-1:0] mode_lat, mode_lat_n;
    logic              pend_valid, pend_valid_n;
    logic [MSEL_W-1:0] pend_mode, pend_mode_n;
    logic [MSEL_W-1:0] cur_mode_n;
    logic              done_n;
    logic              vblank_d;
    logic              vblank_edge;
    logic              valid_req;
    logic [11:0]       rom_value;

    assign valid_req   = mode_req && (int'(mode_sel) < NUM_MODES);
    assign vblank_edge = vblank & ~vblank_d;
    assign mode_busy   = (state != ST_IDLE);
    assign host_dout   = crtc_dout;
    assign dbg_state   = state;

    crtc_mode_rom #(
        .MSEL_W (MSEL_W)
    ) u_rom (
        .mode  (mode_lat),
        .idx   (idx),
        .value (rom_value)
    );

    // State and datapath registers; reset leaves CRTC registers untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 4'd0;
            mode_lat   <= '0;
            pend_valid <= 1'b0;
            pend_mode  <= '0;
            cur_mode   <= '0;
            mode_done  <= 1'b0;
            mode_err   <= 1'b0;
            vblank_d   <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            mode_lat   <= mode_lat_n;
            pend_valid <= pend_valid_n;
            pend_mode  <= pend_mode_n;
            cur_mode   <= cur_mode_n;
            mode_done  <= done_n;
            mode_err   <= mode_req && !valid_req;
            vblank_d   <= vblank;
        end
    end

    // Next-state logic: request latch, vblank sync, register sequencing
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        mode_lat_n   = mode_lat;
        pend_valid_n = pend_valid;
        pend_mode_n  = pend_mode;
        cur_mode_n   = cur_mode;
        done_n       = 1'b0;
        case (state)
            ST_IDLE: begin
                // A fresh request beats one left pending from the last load
                if (valid_req || pend_valid) begin
                    mode_lat_n   = valid_req ? mode_sel : pend_mode;
                    pend_valid_n = 1'b0;
                    idx_n        = 4'd0;
                    state_n      = (SYNC_TO_VBLANK != 0) ? ST_WAIT_VBL : ST_WRITE;
                end
            end
            ST_WAIT_VBL: begin
                if (valid_req) begin
                    mode_lat_n = mode_sel;
                end
                if (vblank_edge) begin
                    state_n = ST_WRITE;
                    idx_n   = 4'd0;
                end
            end
            ST_WRITE: begin
                if (valid_req) begin
                    pend_valid_n = 1'b1;
                    pend_mode_n  = mode_sel;
                end
                if (idx == LAST_IDX) begin
                    state_n    = ST_IDLE;
                    idx_n      = 4'd0;
                    done_n     = 1'b1;
                    cur_mode_n = mode_lat;
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Bus mux: host passes straight through except while the loader writes
    always_comb begin
        host_ready   = 1'b1;
        crtc_wr      = host_wr;
        crtc_address = host_address;
        crtc_din     = host_din;
        if (state == ST_WRITE) begin
            host_ready   = 1'b0;
            crtc_wr      = 2'b11;
            crtc_address = idx;
            crtc_din     = {4'h0, rom_value};
        end
    end

endmodule

// File: doc/crtc_mode_loader.md
Name: crtc_mode_loader

Overview:
- Sequences mode changes for the CRTC timing block by writing a complete 10-register timing set from a built-in mode table over the CRTC register bus.
- Optionally synchronised to the start of vertical blank.
- Shares the same CRTC register bus with a host port, which it stalls while a load is in progress.
- Sits between the system host and the CRTC; owns the CRTC's wr/address/din inputs.

Parameters:
- NUM_MODES, 4: number of entries in the mode table; MSEL_W = max(1, clog2(NUM_MODES)).
- SYNC_TO_VBLANK, 1: 1 = load starts on a vblank rising edge; 0 = load starts the cycle after the request.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode_req  in  1  single-cycle request to load the mode on mode_sel.
- mode_sel  in  MSEL_W  mode table index.
- mode_busy  out  1  high in WAIT_VBL and WRITE.
- mode_done  out  1  one-cycle pulse when a load completes.
- mode_err  out  1  one-cycle pulse when a request had mode_sel >= NUM_MODES.
- cur_mode  out  MSEL_W  last successfully loaded mode.
- host_wr  in  2  host byte write enables.
- host_address  in  4  host register address.
- host_din  in  16  host write data.
- host_dout  out  16  host read data; equals crtc_dout.
- host_ready  out  1  low while the loader owns the bus.
- crtc_wr  out  2  to CRTC wr.
- crtc_address  out  4  to CRTC address.
- crtc_din  out  16  to CRTC din.
- crtc_dout  in  16  from CRTC dout.
- vblank  in  1  CRTC vblank.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- State after reset: IDLE, idx 0, no pending request, cur_mode 0, mode_done and mode_err low, vblank_d 0. CRTC registers are not touched.
- States: IDLE, WAIT_VBL, WRITE.
- Bus ownership outside WRITE: crtc_wr/address/din are a combinational pass-through of host_wr/host_address/host_din, and host_ready = 1.
- Bus ownership in WRITE: host_ready = 0, crtc_wr = 2'b11, crtc_address = idx, crtc_din = {4'h0, table[mode][idx]}. Host writes in this state are dropped; the host must retry once ready is high. host_dout is meaningless while host_ready is low.
- Invalid request: mode_req with mode_sel >= NUM_MODES pulses mode_err the next cycle and is otherwise ignored, in any state.
- IDLE + valid mode_req: latch mode_sel. Go to WAIT_VBL if SYNC_TO_VBLANK = 1, else to WRITE with idx = 0.
- WAIT_VBL:
  - vblank_d registers vblank every cycle; edge = vblank & ~vblank_d.
  - On edge, go to WRITE with idx = 0.
  - A new valid mode_req replaces the latched mode.
  - If vblank is already high on entry, the block waits for the next frame's edge.
- WRITE:
  - One register per cycle, idx 0..9, in the order h_start, h_end, hact_end, hsync_start, hsync_end, v_start, v_end, vact_end, vsync_start, vsync_end.
  - Exits after idx 9. Registers 10/11 (the counters) are untouched unless the optional feature is enabled.
- Completion: in the cycle after the last write, mode_done pulses, cur_mode is updated, and the state returns to IDLE.
- Latency with SYNC_TO_VBLANK = 0: request at cycle t gives writes at t+1..t+10 and mode_done at t+11.
- Latency with SYNC_TO_VBLANK = 1: edge seen at cycle e gives first write at e+1.
- Request during WRITE: held as pending (last one wins). On completion, it re-enters WAIT_VBL/WRITE the cycle after mode_done instead of IDLE.
- Request in the same cycle as the host's write: the loader wins only from the next cycle. A host write in the request cycle passes through.
- Reset mid-load: immediately IDLE, no further writes, pending cleared. The CRTC keeps the partially written values, and cur_mode is reset to 0.
- Table values are 12-bit; the upper nibble of crtc_din is always 0.

Optional Feature:
- Macro: CRTC_LOADER_CNTRST_EN.
- Defined: WRITE extends to idx 0..11, writing 16'h0000 to register 10 (HCNT) and register 11 (VCNT). The raster restarts at 0,0 on the new timing; mode_done is at t+13 in unsynced mode.
- Undefined: 10 writes only; the counters continue free-running.

Decomposition:
- Package crtc_pkg:
  - CRTC register index localparams (H_START=0 … VSYNC_END=9, HCNT=10, VCNT=11).
  - typedef crtc_timing_t: packed struct of ten 12-bit fields.
  - typedef loader_state_t enum.
  - Default mode table constant: 4 modes, e.g. 320x240 NTSC-like, 256x224, 640x480, 320x256.
- Sub-module crtc_mode_rom: combinational lookup (mode, idx) -> 12-bit value.

Test Plan:
- SYNC=0, reset, mode_req with mode_sel=1 at cycle 5 -> crtc_wr=3 at cycles 6..15, addresses 0..9 with mode-1 values, mode_done at 16, cur_mode=1, host_ready low exactly during cycles 6..15.
- SYNC=1, request while vblank=1, then vblank falls and rises at cycle 400 -> first write at 401, none before.
- Host write to address 3, value 16'h0123, while idle -> passes through same cycle. Same host write during WRITE -> no CRTC write of 16'h0123, host_ready=0.
- mode_sel=4 with NUM_MODES=4 -> mode_err pulse, no writes, state stays IDLE.
- Request mode 2 during a load of mode 0 -> mode 0 completes, then mode 2 loads, two mode_done pulses, cur_mode=2.
- Reset asserted at the 5th write -> no writes afterwards, mode_busy=0 and cur_mode=0 next cycle. With CRTC_LOADER_CNTRST_EN: 12 writes, address 10/11 data 0.
